// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ADD/SUB/ADC/SBC ALU, CHUNK bits per clock, LSB chunk first.
// Registered C/Z/V flags; result driven onto a shared bus through an active-low enable.
`default_nettype none

module alu_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] areg,
    input  logic [WIDTH-1:0] breg,
    input  logic             assertBarE,
    output logic [WIDTH-1:0] dbus,
    output logic             aIsZero,
    output logic             busy,
    output logic             done,
    output logic             flagCarry,
    output logic             flagZero,
    output logic             flagOverflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             done_q, done_d;
    logic             fc_q, fc_d;
    logic             fz_q, fz_d;
    logic             fv_q, fv_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             cout_chunk, cin_msb;

    // b_q already holds B' (inverted for subtract), so one adder serves all ops.
    always_comb begin
        a_chunk                 = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk                 = b_q[cnt_q*CHUNK +: CHUNK];
        {cout_chunk, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
        cin_msb                 = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        done_d  = 1'b0;
        fc_d    = fc_q;
        fz_d    = fz_q;
        fv_d    = fv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = areg;
                    b_d     = breg ^ {WIDTH{op[0]}};
                    // ADC/SBC chain from the held carry; ADD/SUB seed with op[0]
                    cy_d    = op[1] ? fc_q : op[0];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[cnt_q*CHUNK +: CHUNK] = sum_chunk;
                cy_d  = cout_chunk;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    fc_d    = cout_chunk;
                    fv_d    = cout_chunk ^ cin_msb;
                    fz_d    = (res_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            done_q  <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            fv_q    <= fv_d;
        end
    end

    assign dbus         = assertBarE ? {WIDTH{1'bz}} : res_q;
    assign aIsZero      = (areg == '0);
    assign busy         = (state_q == S_RUN);
    assign done         = done_q;
    assign flagCarry    = fc_q;
    assign flagZero     = fz_q;
    assign flagOverflow = fv_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: 8-bit and 16-bit instances, scoreboard queues checked by done-driven monitors.
`default_nettype none

module tb_alu_serial;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        start8 = 1'b0, be8 = 1'b0;
    logic [1:0]  op8 = 2'd0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    wire  [7:0]  dbus8;
    logic        az8, busy8, done8, fc8, fz8, fv8;

    logic        start16 = 1'b0, be16 = 1'b0;
    logic [1:0]  op16 = 2'd0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    wire  [15:0] dbus16;
    logic        az16, busy16, done16, fc16, fz16, fv16;

    int   total = 0;
    int   bad = 0;
    int   done_cnt8 = 0;
    int   done_cnt16 = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .areg(a8), .breg(b8),
        .assertBarE(be8), .dbus(dbus8), .aIsZero(az8), .busy(busy8), .done(done8),
        .flagCarry(fc8), .flagZero(fz8), .flagOverflow(fv8)
    );

    alu_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .areg(a16), .breg(b16),
        .assertBarE(be16), .dbus(dbus16), .aIsZero(az16), .busy(busy16), .done(done16),
        .flagCarry(fc16), .flagZero(fz16), .flagOverflow(fv16)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("res8", {24'd0, dbus8}, {16'd0, e8.res});
                check("c8", {31'd0, fc8}, {31'd0, e8.c});
                check("z8", {31'd0, fz8}, {31'd0, e8.z});
                check("v8", {31'd0, fv8}, {31'd0, e8.v});
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            done_cnt16++;
            if (q16.size() == 0) begin
                check("done16_unexpected", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("res16", {16'd0, dbus16}, {16'd0, e16.res});
                check("c16", {31'd0, fc16}, {31'd0, e16.c});
                check("z16", {31'd0, fz16}, {31'd0, e16.z});
                check("v16", {31'd0, fv16}, {31'd0, e16.v});
            end
        end
    end

    task automatic go8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic c, input logic z, input logic v,
                       input bit push);
        exp_t e;
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        e = '{res: {8'd0, r}, c: c, z: z, v: v};
        if (push) q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic c, input logic z, input logic v);
        exp_t e;
        start16 = 1'b1; op16 = o; a16 = a; b16 = b;
        e = '{res: r, c: c, z: z, v: v};
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 20);
        if (!done8) check("timeout8", 32'd0, 32'd1);
    endtask

    task automatic wait16(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done16 && n < 20);
        if (!done16) check("timeout16", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int n;
        int dc;
        repeat (2) @(negedge clk);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_flags8", {29'd0, fc8, fz8, fv8}, 32'd0);
        check("rst_dbus8", {24'd0, dbus8}, 32'd0);
        check("rst_dbus16", {16'd0, dbus16}, 32'd0);
        check("az8_zero", {31'd0, az8}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        go8(2'b00, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b1);
        check("busy8_run", {31'd0, busy8}, 32'd1);
        wait8(n);
        check("lat8", n, 32'd2);
        @(negedge clk);
        check("done8_pulse", {31'd0, done8}, 32'd0);
        check("az8_nonzero", {31'd0, az8}, 32'd0);
        be8 = 1'b1;
        #1 check("bus8_released", {31'd0, (dbus8 !== 8'h4B)}, 32'd1);
        be8 = 1'b0;
        #1 check("bus8_driven", {24'd0, dbus8}, 32'h4B);
        @(negedge clk);

        go8(2'b01, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1); wait8(n); @(negedge clk);
        go8(2'b01, 8'h20, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1); wait8(n); @(negedge clk);
        go8(2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1); wait8(n); @(negedge clk);
        go8(2'b11, 8'h80, 8'h01, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1); wait8(n); @(negedge clk);
        go8(2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1); wait8(n); @(negedge clk);
        go8(2'b10, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1); wait8(n); @(negedge clk);

        // start while busy with other operands must be ignored
        dc = done_cnt8;
        go8(2'b00, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        start8 = 1'b1; op8 = 2'b01; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        wait8(n);
        repeat (4) @(negedge clk);
        check("busy_start_once", done_cnt8 - dc, 32'd1);
        check("q8_empty", q8.size(), 32'd0);

        go16(2'b00, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0);
        wait16(n);
        check("lat16", n, 32'd4);
        go16(2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);
        check("busy16_done_cycle_start", {31'd0, busy16}, 32'd1);
        wait16(n);
        check("lat16_b2b", n, 32'd4);
        repeat (3) @(negedge clk);
        check("q16_empty", q16.size(), 32'd0);

        go8(2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1); wait8(n); @(negedge clk);
        dc = done_cnt8;
        go8(2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("abort_busy8", {31'd0, busy8}, 32'd0);
        check("abort_flags8", {29'd0, fc8, fz8, fv8}, 32'd0);
        check("abort_dbus8", {24'd0, dbus8}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt8 - dc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, multi-cycle successor to the 8-bit add/subtract ALU.
- Computes ADD/SUB/ADC/SBC over WIDTH bits, CHUNK bits per clock, LSB chunk first, with a start/done handshake.
- Holds registered Carry, Zero and Overflow flags, and drives the result onto the shared data bus through an active-low output enable.
- Sits between the A/B registers and dbus in the CPU datapath; ADC/SBC let the control unit chain multi-byte arithmetic.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per clock; NCHUNK = WIDTH/CHUNK (1..16 supported).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request a new operation; sampled only when idle.
op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC; captured with start.
areg  input  WIDTH  operand A; captured with start.
breg  input  WIDTH  operand B; captured with start.
assertBarE  input  1  active-low bus drive enable for result.
dbus  output  WIDTH  result when assertBarE=0, else high-Z.
aIsZero  output  1  combinational: areg == 0.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when result and flags update.
flagCarry  output  1  registered carry (1 = no borrow on subtract).
flagZero  output  1  registered: result == 0.
flagOverflow  output  1  registered signed overflow.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; result, chunk counter, carry chain, busy and done all cleared.
  - flagCarry, flagZero and flagOverflow all 0.
  - dbus follows assertBarE; it drives 0 if enabled.
- States:
  - IDLE: busy=0. On an edge with start=1, capture areg, breg and op; set the chain carry-in; counter=0; go to RUN.
  - RUN: busy=1. Each edge computes chunk[counter] = A_chunk + B'_chunk + chain carry, writes it into the result register, stores the chunk carry-out as the next chain carry, and increments the counter. After the edge that writes chunk NCHUNK-1, go to IDLE.
- Operand B' is breg XOR {WIDTH{subtract}}, where subtract = op[0].
- Chain carry-in per op:
  - ADD: 0.
  - SUB: 1.
  - ADC: flagCarry as held at start.
  - SBC: flagCarry as held at start.
- Latency:
  - Start accepted on edge T0; final chunk written on edge T(NCHUNK).
  - busy is high during cycles T0..T(NCHUNK)-1.
  - done is high for exactly the cycle after T(NCHUNK).
- Flags, updated only on edge T(NCHUNK):
  - flagCarry = carry-out of the MSB.
  - flagZero = (full result == 0).
  - flagOverflow = carry into MSB XOR carry out of MSB.
- Flags and the result register hold until the next completion or reset.
- The result register updates chunk by chunk. Until done, dbus may show a mix of new low chunks and old high chunks; consumers sample only after done.
- start while busy: ignored; no queuing, captured operands unchanged.
- start in the done cycle: accepted (state is IDLE). Back-to-back throughput is one op per NCHUNK+1 cycles.
- areg/breg/op changes after capture: no effect on the op in flight.
- Reset mid-RUN: abort, flags cleared, no done pulse.
- assertBarE: purely combinational gate on dbus, independent of state.
- aIsZero: purely combinational, independent of state.
- All arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, CHUNK=4: ADD 0x3C+0x0F → done 2 cycles after start edge; result 0x4B; C=0, Z=0, V=0; dbus=0x4B with assertBarE=0, Z-state with assertBarE=1.
- SUB 0x10-0x20 → result 0xF0, C=0 (borrow), V=0. Then SUB 0x20-0x20 → 0x00, C=1, Z=1.
- ADD 0x7F+0x01 → 0x80, V=1, C=0. Then SBC 0x80-0x01 with C=0 → 0x7E, V=1, C=1.
- ADD 0xFF+0x01 → 0x00, C=1, Z=1. Then ADC 0x00+0x00 → 0x01, C=0, Z=0 (carry chained).
- start re-asserted while busy with different operands → ignored; first result unchanged; exactly one done pulse. Reset pulled low mid-RUN → busy=0, all flags 0, no done.
- WIDTH=16, CHUNK=4: ADD 0x0FFF+0x0001 → done after 4 cycles; result 0x1000; C=0. Start re-asserted in the done cycle → accepted.
